ru_scheduler: RTL

RU_SCHEDULER -- requirements
Module: ru_scheduler

---
 rtl/ru_scheduler_pkg.sv | 22 ++
 rtl/ru_alloc_scan.sv | 64 ++++++
 rtl/ru_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ru_scheduler_pkg.sv
// Shared definitions for the redundant-unit scheduler: FSM state encoding and width helpers.
// Width macros guard against a zero-width index when a dimension is 1.
`ifndef RU_SCHEDULER_PKG_SV
`define RU_SCHEDULER_PKG_SV

`define RU_CB_W(cols)  (((cols) > 1) ? $clog2(cols) : 1)
`define RU_ROW_W(rows) (((rows) > 1) ? $clog2(rows) : 1)

package ru_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_MAPPED = 3'd2,
    ST_LOAD   = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } ru_state_e;

endpackage

`endif

// File: rtl/ru_alloc_scan.sv
// One scan step: OR-reduce the selected column of the fault matrix and, if faulty,
// give it the next free redundant unit (or flag overflow when all units are taken).
module ru_alloc_scan
  import ru_scheduler_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  parameter int CB     = 2,
  parameter int AW     = 3,
  parameter int NW     = 3
) (
  input  logic [ROWS*COLS-1:0] fault_mat,
  input  logic [CB-1:0]        col,
  input  logic [NUM_RU-1:0]    ru_en_i,
  input  logic [NUM_RU*CB-1:0] map_i,
  input  logic [AW-1:0]        cnt_i,
  input  logic [NW-1:0]        nfault_i,
  input  logic                 ovf_i,
  output logic [NUM_RU-1:0]    ru_en_o,
  output logic [NUM_RU*CB-1:0] map_o,
  output logic [AW-1:0]        cnt_o,
  output logic [NW-1:0]        nfault_o,
  output logic                 ovf_o
);

  logic [COLS-1:0] col_fault_vec;
  logic            col_fault;

  always_comb begin
    col_fault_vec = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        col_fault_vec[c] = col_fault_vec[c] | fault_mat[r*COLS + c];
      end
    end
  end

  assign col_fault = col_fault_vec[col];

  // Units are handed out in ascending order, so the allocated count is also the next free slot.
  always_comb begin
    ru_en_o  = ru_en_i;
    map_o    = map_i;
    cnt_o    = cnt_i;
    nfault_o = nfault_i;
    ovf_o    = ovf_i;
    if (col_fault) begin
      nfault_o = nfault_i + 1'b1;
      if (cnt_i == AW'(NUM_RU)) begin
        ovf_o = 1'b1;
      end else begin
        for (int k = 0; k < NUM_RU; k++) begin
          if (cnt_i == AW'(k)) begin
            ru_en_o[k]        = 1'b1;
            map_o[k*CB +: CB] = col;
          end
        end
        cnt_o = cnt_i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ru_scheduler.sv
// Redundant-unit scheduler: maps faulty systolic columns onto spare units and sequences recompute.
// Define BISR_STICKY_FAULT_EN to OR-accumulate fault matrices across STW runs until reset.
//   state     | meaning
//   IDLE      | nothing mapped since reset
//   SCAN      | one column examined per cycle, tables rebuilt
//   MAPPED    | allocation stable, waiting for mm_start or a new STW result
//   LOAD      | spare units load weights, one row per cycle
//   STREAM    | spare units stream outputs, one row per cycle
//   DONE      | one-cycle completion pulse
module ru_scheduler
  import ru_scheduler_pkg::*;
#(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int NUM_RU = 4,
  localparam int CB     = `RU_CB_W(COLS),
  localparam int RW     = `RU_ROW_W(ROWS),
  localparam int NW     = $clog2(COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stw_complete,
  input  logic [ROWS*COLS-1:0] stw_result_mat,
  input  logic                 mm_start,
  output logic [NUM_RU-1:0]    ru_en,
  output logic [NUM_RU*CB-1:0] ru_col_mapping,
  output logic [NUM_RU-1:0]    ru_set_stationary,
  output logic [NUM_RU-1:0]    ru_fsm_out_sel,
  output logic [RW-1:0]        ru_row_idx,
  output logic                 map_valid,
  output logic                 fault_overflow,
  output logic [NW-1:0]        num_faulty_cols,
  output logic                 mm_busy,
  output logic                 mm_done
);

  localparam int AW = $clog2(NUM_RU + 1);

  ru_state_e               state_q, state_d;
  logic                    stw_q, stw_rise;
  logic                    pend_q, pend_d;
  logic [CB-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [ROWS*COLS-1:0]    fault_q, fault_d;
  logic [NUM_RU-1:0]       ru_en_q, ru_en_d, alloc_en;
  logic [NUM_RU*CB-1:0]    map_q, map_d, alloc_map;
  logic [AW-1:0]           cnt_q, cnt_d, alloc_cnt;
  logic [NW-1:0]           nfault_q, nfault_d, alloc_nfault;
  logic                    ovf_q, ovf_d, alloc_ovf;
  logic                    map_valid_q, map_valid_d;
  logic                    start_scan;

  assign stw_rise = stw_complete & ~stw_q;

  ru_alloc_scan #(
    .ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .CB(CB), .AW(AW), .NW(NW)
  ) u_alloc (
    .fault_mat (fault_q),
    .col       (col_q),
    .ru_en_i   (ru_en_q),
    .map_i     (map_q),
    .cnt_i     (cnt_q),
    .nfault_i  (nfault_q),
    .ovf_i     (ovf_q),
    .ru_en_o   (alloc_en),
    .map_o     (alloc_map),
    .cnt_o     (alloc_cnt),
    .nfault_o  (alloc_nfault),
    .ovf_o     (alloc_ovf)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    col_d       = col_q;
    row_d       = row_q;
    fault_d     = fault_q;
    ru_en_d     = ru_en_q;
    map_d       = map_q;
    cnt_d       = cnt_q;
    nfault_d    = nfault_q;
    ovf_d       = ovf_q;
    map_valid_d = map_valid_q;
    start_scan  = 1'b0;
`ifdef BISR_STICKY_FAULT_EN
    if (stw_rise) fault_d = fault_q | stw_result_mat;
`else
    if (stw_rise) fault_d = stw_result_mat;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (stw_rise) start_scan = 1'b1;
      end
      ST_SCAN: begin
        if (stw_rise) begin
          start_scan = 1'b1;
        end else begin
          ru_en_d  = alloc_en;
          map_d    = alloc_map;
          cnt_d    = alloc_cnt;
          nfault_d = alloc_nfault;
          ovf_d    = alloc_ovf;
          if (col_q == CB'(COLS - 1)) begin
            state_d     = ST_MAPPED;
            map_valid_d = 1'b1;
            col_d       = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_MAPPED: begin
        if (stw_rise) begin
          start_scan = 1'b1;
        end else if (mm_start) begin
          row_d   = '0;
          state_d = (ru_en_q != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (stw_rise) pend_d = 1'b1;
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = ST_STREAM;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (stw_rise) pend_d = 1'b1;
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = ST_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (pend_q || stw_rise) start_scan = 1'b1;
        else                    state_d    = ST_MAPPED;
      end
      default: state_d = ST_IDLE;
    endcase
    // Any rescan, including one deferred behind a recompute, starts from a clean table.
    if (start_scan) begin
      state_d     = ST_SCAN;
      pend_d      = 1'b0;
      col_d       = '0;
      row_d       = '0;
      ru_en_d     = '0;
      map_d       = '0;
      cnt_d       = '0;
      nfault_d    = '0;
      ovf_d       = 1'b0;
      map_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      stw_q       <= 1'b0;
      pend_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      fault_q     <= '0;
      ru_en_q     <= '0;
      map_q       <= '0;
      cnt_q       <= '0;
      nfault_q    <= '0;
      ovf_q       <= 1'b0;
      map_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stw_q       <= stw_complete;
      pend_q      <= pend_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fault_q     <= fault_d;
      ru_en_q     <= ru_en_d;
      map_q       <= map_d;
      cnt_q       <= cnt_d;
      nfault_q    <= nfault_d;
      ovf_q       <= ovf_d;
      map_valid_q <= map_valid_d;
    end
  end

  assign ru_en             = ru_en_q;
  assign ru_col_mapping    = map_q;
  assign num_faulty_cols   = nfault_q;
  assign fault_overflow    = ovf_q;
  assign map_valid         = map_valid_q;
  assign ru_set_stationary = (state_q == ST_LOAD)   ? ru_en_q : '0;
  assign ru_fsm_out_sel    = (state_q == ST_STREAM) ? ru_en_q : '0;
  assign ru_row_idx        = (state_q == ST_LOAD || state_q == ST_STREAM) ? row_q : '0;
  assign mm_busy           = (state_q == ST_LOAD || state_q == ST_STREAM || state_q == ST_DONE);
  assign mm_done           = (state_q == ST_DONE);

endmodule
